// File: rtl/axil_reg_slave_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes, FSM encodings,
// reset polarity and the helpers used by the bus FSMs and the register bank.
package axil_reg_slave_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_WAIT_W  = 2'd1,
        WR_WAIT_AW = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

    // Error responses are only reported when the SLVERR build option is enabled.
    function automatic logic [1:0] resp_of(input logic err);
`ifdef AXIL_SLVERR_EN
        return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`else
        return err ? AXI_RESP_OKAY : AXI_RESP_OKAY;
`endif
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register array behind the AXI4-Lite slave: byte-lane write merge, read-only ID in reg 0,
// combinational read mux and flat export of all register contents.
module axil_reg_bank
    import axil_reg_slave_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = 32'h4D495053,
    parameter int          OFFS_W   = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [OFFS_W-1:0]        wr_offs,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_strb,
    output logic                     wr_err,
    input  logic [OFFS_W-1:0]        rd_offs,
    output logic [31:0]              rd_data,
    output logic                     rd_err,
    output logic [32*NUM_REGS-1:0]   reg_out
);

    localparam int                IW      = $clog2(NUM_REGS);
    localparam logic [OFFS_W-1:0] WIN_END = OFFS_W'(NUM_REGS * 4);

    logic [31:0]   regs_q [1:NUM_REGS-1];
    logic [31:0]   regs_d [1:NUM_REGS-1];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx = wr_offs[IW+1:2];
    assign rd_idx = rd_offs[IW+1:2];
    assign wr_err = (wr_offs >= WIN_END) || (wr_idx == '0);
    assign rd_err = (rd_offs >= WIN_END);

    always_comb begin
        regs_d = regs_q;
        if (wr_en && !wr_err) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                if (wr_idx == IW'(k)) regs_d[k] = byte_merge(regs_q[k], wr_data, wr_strb);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            for (int k = 1; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (!rd_err) begin
            if (rd_idx == '0) rd_data = ID_VALUE;
            for (int k = 1; k < NUM_REGS; k++) begin
                if (rd_idx == IW'(k)) rd_data = regs_q[k];
            end
        end
    end

    assign reg_out[31:0] = ID_VALUE;
    for (genvar k = 1; k < NUM_REGS; k++) begin : g_out
        assign reg_out[32*k +: 32] = regs_q[k];
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: independent write and read FSMs in front of axil_reg_bank.
// Build option AXIL_SLVERR_EN reports SLVERR for out-of-range accesses and reg 0 writes.
module axil_reg_slave
    import axil_reg_slave_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = 32'h4D495053,
    parameter int          OFFS_W   = 28
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            S_AXI_AWADDR,
    input  logic [2:0]             S_AXI_AWPROT,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [31:0]            S_AXI_WDATA,
    input  logic [3:0]             S_AXI_WSTRB,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [31:0]            S_AXI_ARADDR,
    input  logic [2:0]             S_AXI_ARPROT,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [31:0]            S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0] reg_out
);

    wr_state_e         wr_state_q, wr_state_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [OFFS_W-1:0] awoffs_q, awoffs_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;

    rd_state_e         rd_state_q, rd_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              aw_hs, w_hs, ar_hs;
    logic              commit;
    logic [OFFS_W-1:0] cm_offs;
    logic [31:0]       cm_data;
    logic [3:0]        cm_strb;
    logic              wr_err, rd_err;
    logic [31:0]       bank_rdata;

    wire unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[31:OFFS_W], S_AXI_ARADDR[31:OFFS_W]};

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID && wready_q;
    assign ar_hs = S_AXI_ARVALID && arready_q;

    axil_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE),
        .OFFS_W   (OFFS_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (commit),
        .wr_offs (cm_offs),
        .wr_data (cm_data),
        .wr_strb (cm_strb),
        .wr_err  (wr_err),
        .rd_offs (S_AXI_ARADDR[OFFS_W-1:0]),
        .rd_data (bank_rdata),
        .rd_err  (rd_err),
        .reg_out (reg_out)
    );

    // The second half of a split write comes straight off the bus; the first half was captured.
    always_comb begin
        commit  = 1'b0;
        cm_offs = awoffs_q;
        cm_data = wdata_q;
        cm_strb = wstrb_q;
        case (wr_state_q)
            WR_IDLE: begin
                commit  = aw_hs && w_hs;
                cm_offs = S_AXI_AWADDR[OFFS_W-1:0];
                cm_data = S_AXI_WDATA;
                cm_strb = S_AXI_WSTRB;
            end
            WR_WAIT_W: begin
                commit  = w_hs;
                cm_data = S_AXI_WDATA;
                cm_strb = S_AXI_WSTRB;
            end
            WR_WAIT_AW: begin
                commit  = aw_hs;
                cm_offs = S_AXI_AWADDR[OFFS_W-1:0];
            end
            default: commit = 1'b0;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awoffs_d   = aw_hs ? S_AXI_AWADDR[OFFS_W-1:0] : awoffs_q;
        wdata_d    = w_hs ? S_AXI_WDATA : wdata_q;
        wstrb_d    = w_hs ? S_AXI_WSTRB : wstrb_q;
        case (wr_state_q)
            WR_IDLE: begin
                awready_d = 1'b1;
                wready_d  = 1'b1;
                if (aw_hs && !w_hs) begin
                    wr_state_d = WR_WAIT_W;
                    awready_d  = 1'b0;
                end else if (w_hs && !aw_hs) begin
                    wr_state_d = WR_WAIT_AW;
                    wready_d   = 1'b0;
                end
            end
            WR_RESP: begin
                if (bvalid_q && S_AXI_BREADY) begin
                    wr_state_d = WR_IDLE;
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            default: ;
        endcase
        if (commit) begin
            wr_state_d = WR_RESP;
            awready_d  = 1'b0;
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = resp_of(wr_err);
        end
    end

    // Read data is sampled from the bank before any same-edge write lands.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rd_state_d = RD_DATA;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = bank_rdata;
                    rresp_d    = resp_of(rd_err);
                end
            end
            RD_DATA: begin
                if (rvalid_q && S_AXI_RREADY) begin
                    rd_state_d = RD_IDLE;
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= AXI_RESP_OKAY;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= AXI_RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    always_ff @(posedge clk) begin
        awoffs_q <= awoffs_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave (NUM_REGS=8, default parameters).
module tb_axil_reg_slave;

    localparam int          NUM_REGS = 8;
    localparam logic [31:0] ID       = 32'h4D495053;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0]  EXP_ERR  = 2'b10;
`else
    localparam logic [1:0]  EXP_ERR  = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [1:0] bresp, rresp;
    logic [32*NUM_REGS-1:0] reg_out;
    logic [32*NUM_REGS-1:0] snap;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    axil_reg_slave #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID), .OFFS_W(28)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 10) begin
            tick();
            n++;
        end
        chk("wr_bvalid_seen", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 10) begin
            tick();
            n++;
        end
        chk("rd_rvalid_seen", {31'd0, rvalid}, 32'd1);
        d = rdata;
        resp = rresp;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int seen;

        rst = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        tick(); tick();
        chk("rst_awready", {31'd0, awready}, 0);
        chk("rst_wready",  {31'd0, wready}, 0);
        chk("rst_arready", {31'd0, arready}, 0);
        chk("rst_bvalid",  {31'd0, bvalid}, 0);
        chk("rst_rvalid",  {31'd0, rvalid}, 0);
        chk("rst_rdata",   rdata, 0);
        chk("rst_resps",   {28'd0, bresp, rresp}, 0);
        chk("rst_reg1",    reg_out[63:32], 0);
        chk("rst_reg0_id", reg_out[31:0], ID);
        rst = 1'b1;
        tick();
        chk("idle_awready", {31'd0, awready}, 1);

        // 1: AW and W together, window offset decode ignores upper address bits
        awaddr = 32'h1000_0004; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 1;
        tick();
        awvalid = 0; wvalid = 0;
        chk("t1_bvalid", {31'd0, bvalid}, 1);
        chk("t1_bresp",  {30'd0, bresp}, 0);
        chk("t1_reg1",   reg_out[63:32], 32'hDEADBEEF);
        chk("t1_awready_resp", {31'd0, awready}, 0);
        tick();
        chk("t1_bvalid_done", {31'd0, bvalid}, 0);
        chk("t1_awready_back", {31'd0, awready}, 1);

        // 2: W three cycles before AW, single byte lane
        do_write(32'h08, 32'h11223344, 4'hF, rs);
        wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1; bready = 1;
        tick();
        wvalid = 0;
        chk("t2_wready_drop", {31'd0, wready}, 0);
        chk("t2_awready_hold", {31'd0, awready}, 1);
        tick(); tick();
        chk("t2_no_commit", reg_out[95:64], 32'h11223344);
        chk("t2_no_bvalid", {31'd0, bvalid}, 0);
        awaddr = 32'h08; awvalid = 1;
        tick();
        awvalid = 0;
        chk("t2_bvalid", {31'd0, bvalid}, 1);
        chk("t2_reg2", reg_out[95:64], 32'h112233AA);
        tick();

        // 3: read ID with RREADY held low
        araddr = 32'h0; arvalid = 1; rready = 0;
        tick();
        arvalid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_rvalid", {31'd0, rvalid}, 1);
            chk("t3_rdata", rdata, ID);
            chk("t3_arready", {31'd0, arready}, 0);
            tick();
        end
        rready = 1;
        tick();
        chk("t3_rvalid_done", {31'd0, rvalid}, 0);
        chk("t3_arready_back", {31'd0, arready}, 1);

        // 4: out-of-range and reg 0 accesses
        snap = reg_out;
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, rs);
        chk("t4_bresp_oor", {30'd0, rs}, {30'd0, EXP_ERR});
        do_write(32'h00, 32'h12345678, 4'hF, rs);
        chk("t4_bresp_reg0", {30'd0, rs}, {30'd0, EXP_ERR});
        chk("t4_regs_same_lo", reg_out[127:0] ^ snap[127:0] ? 32'd1 : 32'd0, 0);
        chk("t4_regs_same_hi", reg_out[255:128] ^ snap[255:128] ? 32'd1 : 32'd0, 0);
        do_read(32'h40, rd, rs);
        chk("t4_rdata_oor", rd, 0);
        chk("t4_rresp_oor", {30'd0, rs}, {30'd0, EXP_ERR});
        do_read(32'h08, rd, rs);
        chk("t4_rd_reg2", rd, 32'h112233AA);
        chk("t4_rresp_ok", {30'd0, rs}, 0);

        // 5: read and write of reg 1 on the same edge
        do_write(32'h04, 32'h1, 4'hF, rs);
        awaddr = 32'h04; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        araddr = 32'h04; arvalid = 1; rready = 0;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("t5_rdata_old", rdata, 32'h1);
        chk("t5_reg1_new", reg_out[63:32], 32'h2);
        rready = 1;
        tick();
        do_read(32'h04, rd, rs);
        chk("t5_rdata_new", rd, 32'h2);

        // 6: async reset while a response is pending
        awaddr = 32'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        tick();
        awvalid = 0; wvalid = 0;
        chk("t6_reg3", reg_out[127:96], 32'h55);
        tick();
        chk("t6_bvalid_pending", {31'd0, bvalid}, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_bvalid_rst", {31'd0, bvalid}, 0);
        chk("t6_awready_rst", {31'd0, awready}, 0);
        chk("t6_reg1_clr", reg_out[63:32], 0);
        chk("t6_reg3_clr", reg_out[127:96], 0);
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bvalid) seen++;
        end
        chk("t6_no_bvalid_after", seen, 0);
        chk("t6_awready_after", {31'd0, awready}, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
